// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-RAM port arbiter: read-owner encoding,
// starvation-counter width and the MAX_WAIT range check.
package dmem_port_arbiter_pkg;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_MEM  = 2'd2;

  localparam int unsigned WAIT_CNT_W = 4;

  function automatic bit max_wait_ok(input int unsigned v);
    return (v >= 1) && (v <= 15);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester and RAM-side signals of the data-RAM port arbiter.
// slave = arbiter view, master = fetch/MEM stages plus RAM macro view.
interface dmem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BEW = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              mem_req;
  logic [BEW-1:0]    mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              ram_en;
  logic [BEW-1:0]    ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, mem_req, mem_wen, mem_addr, mem_wdata, ram_rdata,
    output if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
           ram_en, ram_wen, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, mem_req, mem_wen, mem_addr, mem_wdata, ram_rdata,
    input  if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
           ram_en, ram_wen, ram_addr, ram_wdata
  );

endinterface

// File: rtl/dmem_port_arbiter_wait_cnt.sv
// Saturating wait counter: counts denied IF cycles up to MAX, flags saturation.
module arb_wait_cnt
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  inc,
  input  logic                  clr,
  output logic [WAIT_CNT_W-1:0] cnt,
  output logic                  sat
);

  localparam logic [WAIT_CNT_W-1:0] MAX_V = WAIT_CNT_W'(MAX);

  assign sat = (cnt == MAX_V);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + WAIT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter (IF read-only, MEM load/store) for a 1-cycle-latency RAM.
// Define DMEM_ARB_RR_EN for round-robin; default is MEM priority with IF starvation escape.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  dmem_port_arbiter_if.slave   bus
);

  localparam int unsigned BEW = DATA_W / 8;

  if (!max_wait_ok(MAX_WAIT)) begin : g_bad_max_wait
    $error("dmem_port_arbiter: MAX_WAIT must be in 1..15");
  end

  logic                  if_gnt_c;
  logic                  mem_gnt_c;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  wait_sat;
  logic [1:0]            rd_owner;
  logic [DATA_W-1:0]     if_rdata_p1;
  logic [DATA_W-1:0]     mem_rdata_p1;
  logic                  unused_wait;

  arb_wait_cnt #(.MAX(MAX_WAIT)) u_wait_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (bus.if_req && !if_gnt_c),
    .clr    (if_gnt_c || !bus.if_req),
    .cnt    (wait_cnt),
    .sat    (wait_sat)
  );

`ifdef DMEM_ARB_RR_EN
  logic [1:0] rr_last;

  // On contention the side that did not win last time goes first.
  always_comb begin
    mem_gnt_c = bus.mem_req && (!bus.if_req || (rr_last == OWN_IF));
    if_gnt_c  = bus.if_req && !mem_gnt_c;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_last <= OWN_IF;
    end else if (if_gnt_c) begin
      rr_last <= OWN_IF;
    end else if (mem_gnt_c) begin
      rr_last <= OWN_MEM;
    end
  end

  assign unused_wait = (^wait_cnt) ^ wait_sat;
`else
  // MEM has priority unless IF has been denied MAX_WAIT cycles in a row.
  always_comb begin
    mem_gnt_c = bus.mem_req && !(wait_sat && bus.if_req);
    if_gnt_c  = bus.if_req && !mem_gnt_c;
  end

  assign unused_wait = ^wait_cnt;
`endif

  assign bus.if_gnt  = if_gnt_c;
  assign bus.mem_gnt = mem_gnt_c;

  always_comb begin
    bus.ram_en    = if_gnt_c || mem_gnt_c;
    bus.ram_wen   = {BEW{1'b0}};
    bus.ram_addr  = {ADDR_W{1'b0}};
    bus.ram_wdata = {DATA_W{1'b0}};
    if (mem_gnt_c) begin
      bus.ram_wen   = bus.mem_wen;
      bus.ram_addr  = bus.mem_addr;
      bus.ram_wdata = bus.mem_wdata;
    end else if (if_gnt_c) begin
      bus.ram_addr  = bus.if_addr;
    end
  end

  // ---- p1: RAM read data returns; route it to whoever issued the read ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_owner <= OWN_NONE;
    end else if (if_gnt_c) begin
      rd_owner <= OWN_IF;
    end else if (mem_gnt_c && (bus.mem_wen == {BEW{1'b0}})) begin
      rd_owner <= OWN_MEM;
    end else begin
      rd_owner <= OWN_NONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_rdata_p1  <= '0;
      mem_rdata_p1 <= '0;
    end else begin
      if (rd_owner == OWN_IF) begin
        if_rdata_p1 <= bus.ram_rdata;
      end
      if (rd_owner == OWN_MEM) begin
        mem_rdata_p1 <= bus.ram_rdata;
      end
    end
  end

  // Live RAM data during the valid cycle, captured copy afterwards.
  assign bus.if_rvalid  = (rd_owner == OWN_IF);
  assign bus.mem_rvalid = (rd_owner == OWN_MEM);
  assign bus.if_rdata   = bus.if_rvalid  ? bus.ram_rdata : if_rdata_p1;
  assign bus.mem_rdata  = bus.mem_rvalid ? bus.ram_rdata : mem_rdata_p1;

endmodule
